// File: rtl/cam_capture_axis.sv
// -----------------------------------------------------------------------------
// cam_capture_axis
//   Captures an 8-bit parallel camera bus (vsync/href/data) and emits pixels
//   on an AXI4-Stream video master through a first-word-fall-through FIFO.
//
// Ports
//   aclk, aresetn          : pixel clock, asynchronous active-low reset
//   cam_vsync/href/data    : camera bus (vsync high = vertical blank)
//   cfg_enable             : capture enable, honoured at frame boundaries
//   cfg_mode               : 0 RGB565->RGB888, 1 YUV422 pass, 2/3 RAW8
//   ovf_clr                : clears ovf_sticky (a same-cycle overflow wins)
//   m_axis_video_*         : AXIS master (tuser = SOF, tlast = EOL)
//   line_width             : pixel count of the last completed line
//   frame_lines            : line count of the last completed frame
//   frame_cnt              : completed frames, wraps
//   ovf_sticky             : FIFO overflow seen
//   busy                   : FSM not idle
// -----------------------------------------------------------------------------
module cam_capture_axis #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 16,
    parameter int CNT_W            = 12
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cam_vsync,
    input  logic                        cam_href,
    input  logic [7:0]                  cam_data,
    input  logic                        cfg_enable,
    input  logic [1:0]                  cfg_mode,
    input  logic                        ovf_clr,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_video_tdata,
    output logic                        m_axis_video_tvalid,
    input  logic                        m_axis_video_tready,
    output logic                        m_axis_video_tuser,
    output logic                        m_axis_video_tlast,
    output logic [CNT_W-1:0]            line_width,
    output logic [CNT_W-1:0]            frame_lines,
    output logic [15:0]                 frame_cnt,
    output logic                        ovf_sticky,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ACTIVE,
        DROP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // registered camera inputs and their one-cycle-delayed copies
    logic       r_vs, r_vs_d, r_hr, r_hr_d;
    logic [7:0] r_d;

    logic w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;

    // byte assembly / hold register
    logic [1:0]  r_mode;
    logic        r_phase;
    logic [7:0]  r_hi;
    logic        r_hold_vld;
    logic [23:0] r_hold_pix;
    logic        r_sof_pend;

    logic        w_two_byte, w_byte_vld, w_pix_vld, w_start;
    logic [4:0]  w_r, w_b;
    logic [5:0]  w_g;
    logic [23:0] w_pix;

    // FIFO
    logic [25:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        w_full, w_empty, w_pop, w_push, w_ovf, w_wr;
    logic [25:0] w_push_word, w_out;

    // statistics
    logic [CNT_W-1:0] r_pix_cnt, r_line_cnt;

    // -------------------------------------------------------------------------
    // Input registration and edge detection
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_hr   <= 1'b0;
            r_hr_d <= 1'b0;
            r_d    <= '0;
        end else begin
            r_vs   <= cam_vsync;
            r_vs_d <= r_vs;
            r_hr   <= cam_href;
            r_hr_d <= r_hr;
            r_d    <= cam_data;
        end
    end

    assign w_vs_rise =  r_vs & ~r_vs_d;
    assign w_vs_fall = ~r_vs &  r_vs_d;
    assign w_hr_rise =  r_hr & ~r_hr_d;
    assign w_hr_fall = ~r_hr &  r_hr_d;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (cfg_enable) w_state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (w_vs_rise && !cfg_enable) w_state_nxt = IDLE;
                else if (w_vs_fall)           w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                // frame end has priority so a frame always closes cleanly
                if (w_vs_rise)  w_state_nxt = cfg_enable ? WAIT_FRAME : IDLE;
                else if (w_ovf) w_state_nxt = DROP;
            end
            DROP: begin
                if (w_vs_rise) w_state_nxt = cfg_enable ? WAIT_FRAME : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // -------------------------------------------------------------------------
    // Byte assembly and pixel formatting
    // -------------------------------------------------------------------------
    assign w_start    = (r_state == WAIT_FRAME) && w_vs_fall;
    assign w_two_byte = (r_mode == 2'd0) || (r_mode == 2'd1);
    assign w_byte_vld = (r_state == ACTIVE) && r_hr;
    assign w_pix_vld  = w_byte_vld && (!w_two_byte || r_phase);

    assign w_r = r_hi[7:3];
    assign w_g = {r_hi[2:0], r_d[7:5]};
    assign w_b = r_d[4:0];

    always_comb begin
        w_pix = '0;
        case (r_mode)
            2'd0:    w_pix = {w_r, w_r[4:2], w_g, w_g[5:4], w_b, w_b[4:2]};
            2'd1:    w_pix = {8'h00, r_hi, r_d};
            default: w_pix = {16'h0000, r_d};
        endcase
    end

    // A held pixel leaves either when the next pixel completes (eol=0) or
    // at the href fall (eol=1); the two cannot coincide since pixels only
    // complete while registered href is high.
    assign w_push      = (r_state == ACTIVE) && r_hold_vld && (w_pix_vld || w_hr_fall);
    assign w_push_word = {r_sof_pend, w_hr_fall, r_hold_pix};

    assign w_pop = ~w_empty & m_axis_video_tready;
    assign w_ovf = w_push & w_full & ~w_pop;
    assign w_wr  = w_push & ~w_ovf;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mode     <= '0;
            r_phase    <= 1'b0;
            r_hi       <= '0;
            r_hold_vld <= 1'b0;
            r_hold_pix <= '0;
            r_sof_pend <= 1'b0;
        end else begin
            if (w_start) r_mode <= cfg_mode;

            // phase is held clear while href is low, so every line starts on a high byte
            if (!r_hr)                          r_phase <= 1'b0;
            else if (w_byte_vld && w_two_byte)  r_phase <= ~r_phase;

            if (w_byte_vld && !r_phase) r_hi <= r_d;

            if (r_state != ACTIVE) begin
                r_hold_vld <= 1'b0;
            end else if (w_pix_vld) begin
                r_hold_vld <= 1'b1;
                r_hold_pix <= w_pix;
            end else if (w_hr_fall) begin
                r_hold_vld <= 1'b0;
            end

            if (w_start)   r_sof_pend <= 1'b1;
            else if (w_wr) r_sof_pend <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics and overflow flag
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            line_width  <= '0;
            frame_lines <= '0;
            frame_cnt   <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            if (w_hr_rise)
                r_pix_cnt <= w_pix_vld ? CNT_W'(1) : '0;
            else if (w_pix_vld && (r_pix_cnt != '1))
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);

            if (w_start)
                r_line_cnt <= '0;
            else if (w_wr && w_hr_fall && (r_line_cnt != '1))
                r_line_cnt <= r_line_cnt + CNT_W'(1);

            if (w_wr && w_hr_fall) line_width <= r_pix_cnt;

            if (w_vs_rise && (r_state == ACTIVE)) begin
                frame_lines <= r_line_cnt;
                frame_cnt   <= frame_cnt + 16'd1;
            end

            if (w_ovf)        ovf_sticky <= 1'b1;
            else if (ovf_clr) ovf_sticky <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // First-word-fall-through FIFO, entries {sof, eol, pixel[23:0]}
    // -------------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge aclk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_push_word;
    end

    assign w_out = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    assign m_axis_video_tvalid = ~w_empty;
    assign m_axis_video_tuser  = w_out[25];
    assign m_axis_video_tlast  = w_out[24];
    assign m_axis_video_tdata  = AXIS_TDATA_WIDTH'(w_out[23:0]);

endmodule

// File: doc/cam_capture_axis.md
CAM_CAPTURE_AXIS -- requirements
Module: cam_capture_axis

Interface
REQ-001 Parameters SHALL be:
- AXIS_TDATA_WIDTH, default 32, output data width (24 or 32); bits above 23 are zero.
- FIFO_DEPTH, default 16, output FIFO entries (power of 2, >=4).
- CNT_W, default 12, width of the line and pixel counters.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- aclk  in  1  single clock; camera pixel clock.
- aresetn  in  1  reset; asynchronous, active-low.
- cam_vsync  in  1  frame sync; high marks vertical blank.
- cam_href  in  1  line valid.
- cam_data  in  8  camera byte.
- cfg_enable  in  1  capture enable.
- cfg_mode  in  2  pixel mode: 0 RGB565, 1 YUV422 passthrough, 2 RAW8, 3 reserved (treated as 2).
- ovf_clr  in  1  clears ovf_sticky.
- m_axis_video_tdata  out  AXIS_TDATA_WIDTH  pixel.
- m_axis_video_tvalid  out  1  valid.
- m_axis_video_tready  in  1  ready.
- m_axis_video_tuser  out  1  SOF, first pixel of a frame.
- m_axis_video_tlast  out  1  EOL, last pixel of a line.
- line_width  out  CNT_W  pixel count of the last completed line.
- frame_lines  out  CNT_W  line count of the last completed frame.
- frame_cnt  out  16  count of completed frames; wraps.
- ovf_sticky  out  1  overflow seen.
- busy  out  1  state is not IDLE.

Function
REQ-003 cam_vsync, cam_href and cam_data SHALL be registered once on entry; all edge detection SHALL use the registered copies.
REQ-004 The FSM SHALL have four states: IDLE, WAIT_FRAME, ACTIVE, DROP.
REQ-005 IDLE SHALL move to WAIT_FRAME when cfg_enable=1.
REQ-006 WAIT_FRAME SHALL move to ACTIVE on the falling edge of the registered vsync, latching cfg_mode for the whole frame.
REQ-007 ACTIVE SHALL move to DROP on overflow (REQ-014).
REQ-008 ACTIVE SHALL move to WAIT_FRAME on the vsync rising edge.
REQ-009 DROP SHALL move to WAIT_FRAME on the vsync rising edge.
REQ-010 cfg_enable=0 SHALL take effect only at the vsync rising edge: the current frame completes, then the FSM enters IDLE.
REQ-011 Byte assembly:
- Modes 0 and 1: two bytes per pixel; the first byte while href is high is the high byte.
- Mode 2: one byte per pixel.
- A pair counter SHALL reset at every href rising edge.
- An odd trailing byte at the href falling edge SHALL be discarded.
REQ-012 Pixel formats:
- Mode 0 (RGB565 to RGB888 with bit replication): tdata[23:16]={R,R[4:2]}, [15:8]={G,G[5:4]}, [7:0]={B,B[4:2]}.
- Mode 1: tdata[15:0]={hi,lo}, upper bits zero.
- Mode 2: tdata[7:0]=byte, upper bits zero.
REQ-013 One-pixel hold register:
- Each assembled pixel SHALL be held until the next pixel or the href falling edge.
- On the next pixel, the held pixel SHALL be pushed with eol=0.
- On the href falling edge, it SHALL be pushed with eol=1.
- The first pixel pushed after entering ACTIVE SHALL carry sof=1.
- Push latency SHALL be at most 2 cycles after the completing byte; the EOL pixel SHALL be pushed 1 cycle after the registered href falls.
REQ-014 Overflow: a push while the FIFO is full SHALL drop the pixel, set ovf_sticky and enter DROP. No further pushes SHALL occur until the next frame. Pixels already in the FIFO SHALL still drain.
REQ-015 The output FIFO SHALL be first-word-fall-through, with each entry holding {sof, eol, pixel}:
- tvalid = FIFO not empty.
- An entry pops when tvalid and tready are both 1.
- tdata/tuser/tlast SHALL hold stable while tvalid=1 and tready=0.
- Simultaneous push and pop at full SHALL succeed with no overflow; at empty, the pushed word SHALL appear on the next cycle.
REQ-016 Statistics:
- The pixel counter SHALL reset at each href rise; line_width SHALL load it at each EOL push.
- The line counter SHALL count EOL pushes; frame_lines SHALL load it and frame_cnt SHALL increment at each vsync rising edge that ends an ACTIVE frame.
- DROP frames SHALL update neither frame_lines nor frame_cnt.
- Counters SHALL saturate at all-ones.
REQ-017 ovf_clr SHALL clear ovf_sticky; if an overflow occurs in the same cycle, set SHALL win.

Reset
REQ-018 While aresetn=0, the block SHALL be in state IDLE with the FIFO empty. All outputs SHALL be 0: tvalid, tuser, tlast, tdata, line_width, frame_lines, frame_cnt, ovf_sticky, busy.
REQ-019 Reset assertion mid-frame SHALL flush the FIFO immediately.
REQ-020 After deassertion, capture SHALL begin only at the next full vsync falling edge; no partial frame SHALL be output.

Verification
REQ-021 Mode 0, tready=1, 4 lines of 8 pixels -> 32 beats; tuser only on beat 0; tlast on beats 7, 15, 23, 31; line_width=8, frame_lines=4, frame_cnt=1.
REQ-022 Mode 0, byte pair 0xF8,0x1F -> tdata=0x00FF00FF; mode 1, pair 0x12,0x34 -> 0x00001234; mode 2, byte 0xA5 -> 0x000000A5.
REQ-023 FIFO_DEPTH=16, tready=0, 20-pixel line -> exactly 16 beats held; ovf_sticky=1; no further output that frame; next frame output intact with tuser=1 on its first beat.
REQ-024 Mode 0, line of 9 bytes -> 4 pixels, last pixel has tlast=1, line_width=4.
REQ-025 Random tready toggling across a frame -> output stream identical to the tready=1 run, with tdata stable whenever tvalid=1 and tready=0.
REQ-026 aresetn pulsed low mid-line -> outputs 0 immediately; capture resumes at the next frame with tuser=1 on its first beat.
